// File: rtl/alu_operand_stage_pkg.sv
// Shared widths, ALU op encodings and the ID/EX payload type for the ALU operand stage.
package alu_operand_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned REGW = 5;
  localparam int unsigned ACW  = 3;

  localparam logic [ACW-1:0] ALU_ADD = 3'b000;
  localparam logic [ACW-1:0] ALU_SUB = 3'b001;
  localparam logic [ACW-1:0] ALU_AND = 3'b010;
  localparam logic [ACW-1:0] ALU_OR  = 3'b011;
  localparam logic [ACW-1:0] ALU_SLT = 3'b101;

  typedef struct packed {
    logic [ACW-1:0]  alucontrol;
    logic            alusrc;
    logic            regwrite;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
  } op_t;

  // A producer matches a source only when it writes, targets that index, and the index is not x0.
  function automatic logic idx_hit(input logic rw, input logic [REGW-1:0] rd,
                                   input logic [REGW-1:0] src);
    return rw && (rd == src) && (src != '0);
  endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode-side and ALU-side handshake/payload bundle of the ALU operand stage.
interface alu_operand_stage_if;
  import alu_operand_stage_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [ACW-1:0]       in_alucontrol;
  logic                 in_alusrc;
  logic [REGW-1:0]      in_rs1;
  logic [REGW-1:0]      in_rs2;
  logic [REGW-1:0]      in_rd;
  logic                 in_regwrite;
  logic [XLEN-1:0]      in_rd1;
  logic [XLEN-1:0]      in_rd2;
  logic [XLEN-1:0]      in_imm;

  logic                 out_valid;
  logic                 out_ready;
  logic [ACW-1:0]       alucontrol;
  logic [XLEN-1:0]      srca;
  logic [XLEN-1:0]      srcb;
  logic [REGW-1:0]      out_rd;
  logic                 out_regwrite;

  modport master (
    output in_valid, in_alucontrol, in_alusrc, in_rs1, in_rs2, in_rd, in_regwrite,
           in_rd1, in_rd2, in_imm, out_ready,
    input  in_ready, out_valid, alucontrol, srca, srcb, out_rd, out_regwrite
  );

  modport slave (
    input  in_valid, in_alucontrol, in_alusrc, in_rs1, in_rs2, in_rd, in_regwrite,
           in_rd1, in_rd2, in_imm, out_ready,
    output in_ready, out_valid, alucontrol, srca, srcb, out_rd, out_regwrite
  );

endinterface

// File: rtl/alu_operand_stage_fwd_sel.sv
// Operand forwarding mux: EX/MEM beats MEM/WB, x0 never forwarded, otherwise the default value.
module alu_operand_stage_fwd_sel
  import alu_operand_stage_pkg::*;
(
  input  logic [REGW-1:0] idx,
  input  logic [XLEN-1:0] rfdata,
  input  logic            exm_regwrite,
  input  logic [REGW-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_result,
  input  logic            wb_regwrite,
  input  logic [REGW-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_result,
  input  logic [XLEN-1:0] hold_val,
  input  logic            hold_en,
  output logic [XLEN-1:0] operand_c
);

  always_comb begin
    operand_c = hold_en ? hold_val : rfdata;
    if (idx_hit(exm_regwrite, exm_rd, idx)) begin
      operand_c = exm_result;
    end else if (idx_hit(wb_regwrite, wb_rd, idx)) begin
      operand_c = wb_result;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX stage ahead of the ALU: valid/ready payload register with operand forwarding,
// hold-time snooping of late producers, and branch/jump flush.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  alu_operand_stage_if.slave   bus,
  input  logic                 flush,
  input  logic                 exm_regwrite,
  input  logic [REGW-1:0]      exm_rd,
  input  logic [XLEN-1:0]      exm_result,
  input  logic                 wb_regwrite,
  input  logic [REGW-1:0]      wb_rd,
  input  logic [XLEN-1:0]      wb_result
);

  logic            valid_q;
  op_t             op_q;
  op_t             op_d;
  logic [XLEN-1:0] srca_q;
  logic [XLEN-1:0] srcb_q;
  logic [XLEN-1:0] cap_a_c;
  logic [XLEN-1:0] cap_b_c;
  logic [XLEN-1:0] snp_a_c;
  logic [XLEN-1:0] snp_b_c;
  logic            in_ready_c;
  logic            capture_c;
  logic            consume_c;

  assign in_ready_c = !valid_q || bus.out_ready;
  assign capture_c  = bus.in_valid && in_ready_c && !flush;
  assign consume_c  = valid_q && bus.out_ready;

  always_comb begin
    op_d            = '0;
    op_d.alucontrol = bus.in_alucontrol;
    op_d.alusrc     = bus.in_alusrc;
    op_d.regwrite   = bus.in_regwrite;
    op_d.rs1        = bus.in_rs1;
    op_d.rs2        = bus.in_rs2;
    op_d.rd         = bus.in_rd;
  end

  // Capture-time selection from the register-file read data.
  alu_operand_stage_fwd_sel u_cap_a (
    .idx(bus.in_rs1), .rfdata(bus.in_rd1),
    .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .hold_val('0), .hold_en(1'b0), .operand_c(cap_a_c)
  );

  alu_operand_stage_fwd_sel u_cap_b (
    .idx(bus.in_rs2), .rfdata(bus.in_rd2),
    .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .hold_val('0), .hold_en(1'b0), .operand_c(cap_b_c)
  );

  // Hold-time snoop: a producer that retires while we stall refreshes the held operand.
  alu_operand_stage_fwd_sel u_snp_a (
    .idx(op_q.rs1), .rfdata(srca_q),
    .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .hold_val(srca_q), .hold_en(1'b1), .operand_c(snp_a_c)
  );

  alu_operand_stage_fwd_sel u_snp_b (
    .idx(op_q.rs2), .rfdata(srcb_q),
    .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .hold_val(srcb_q), .hold_en(1'b1), .operand_c(snp_b_c)
  );

  // Flush wins over capture and consume; regwrite is cleared whenever the beat goes away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      srca_q  <= '0;
      srcb_q  <= '0;
    end else if (flush) begin
      valid_q       <= 1'b0;
      op_q.regwrite <= 1'b0;
    end else if (capture_c) begin
      valid_q <= 1'b1;
      op_q    <= op_d;
      srca_q  <= cap_a_c;
      srcb_q  <= bus.in_alusrc ? bus.in_imm : cap_b_c;
    end else if (consume_c) begin
      valid_q       <= 1'b0;
      op_q.regwrite <= 1'b0;
    end else if (valid_q) begin
      srca_q <= snp_a_c;
      srcb_q <= op_q.alusrc ? srcb_q : snp_b_c;
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = valid_q;
  assign bus.alucontrol   = op_q.alucontrol;
  assign bus.srca         = srca_q;
  assign bus.srcb         = srcb_q;
  assign bus.out_rd       = op_q.rd;
  assign bus.out_regwrite = op_q.regwrite;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed plus random bench for alu_operand_stage against a cycle-level behavioural model.
module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush;
  logic        exm_regwrite;
  logic [4:0]  exm_rd;
  logic [31:0] exm_result;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model of the beat currently presented to the ALU.
  logic        m_valid;
  logic [2:0]  m_alu;
  logic [31:0] m_srca, m_srcb;
  logic [4:0]  m_rd, m_rs1, m_rs2;
  logic        m_rw, m_alusrc;

  always #5 clk = ~clk;

  alu_operand_stage_if bus ();

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
    .exm_regwrite(exm_regwrite), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] s, input logic [31:0] dflt);
    if (s != 5'd0 && exm_regwrite && exm_rd == s) return exm_result;
    if (s != 5'd0 && wb_regwrite && wb_rd == s) return wb_result;
    return dflt;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_alu = '0; m_srca = '0; m_srcb = '0;
    m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_rw = 1'b0; m_alusrc = 1'b0;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_alucontrol = ALU_ADD; bus.in_alusrc = 1'b0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0; bus.in_regwrite = 1'b0;
    bus.in_rd1 = '0; bus.in_rd2 = '0; bus.in_imm = '0; bus.out_ready = 1'b1;
    flush = 1'b0; exm_regwrite = 1'b0; exm_rd = '0; exm_result = '0;
    wb_regwrite = 1'b0; wb_rd = '0; wb_result = '0;
  endtask

  task automatic chk_out(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'(m_valid));
    chk({tag, "_out_regwrite"}, 32'(bus.out_regwrite), 32'(m_valid && m_rw));
    if (m_valid) begin
      chk({tag, "_alucontrol"}, 32'(bus.alucontrol), 32'(m_alu));
      chk({tag, "_srca"}, bus.srca, m_srca);
      chk({tag, "_srcb"}, bus.srcb, m_srcb);
      chk({tag, "_out_rd"}, 32'(bus.out_rd), 32'(m_rd));
    end
  endtask

  // Called at a falling edge with inputs already driven; advances one clock.
  task automatic step(input string tag);
    logic ready;
    #1;
    ready = !m_valid || bus.out_ready;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'(ready));
    if (flush) begin
      m_valid = 1'b0; m_rw = 1'b0;
    end else if (bus.in_valid && ready) begin
      m_valid = 1'b1; m_alu = bus.in_alucontrol; m_rd = bus.in_rd; m_rw = bus.in_regwrite;
      m_rs1 = bus.in_rs1; m_rs2 = bus.in_rs2; m_alusrc = bus.in_alusrc;
      m_srca = fwd(bus.in_rs1, bus.in_rd1);
      m_srcb = bus.in_alusrc ? bus.in_imm : fwd(bus.in_rs2, bus.in_rd2);
    end else if (m_valid && bus.out_ready) begin
      m_valid = 1'b0; m_rw = 1'b0;
    end else if (m_valid) begin
      m_srca = fwd(m_rs1, m_srca);
      if (!m_alusrc) m_srcb = fwd(m_rs2, m_srcb);
    end
    @(posedge clk);
    #1;
    chk_out(tag);
    @(negedge clk);
  endtask

  task automatic beat(input logic [2:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] rd1, input logic [31:0] rd2);
    bus.in_valid = 1'b1; bus.in_alucontrol = op; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
    bus.in_rd1 = rd1; bus.in_rd2 = rd2; bus.in_rd = 5'd10; bus.in_regwrite = 1'b1;
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_srca", bus.srca, 32'd0);
    chk("rst_srcb", bus.srcb, 32'd0);
    chk("rst_alucontrol", 32'(bus.alucontrol), 32'd0);
    chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
    chk("rst_out_regwrite", 32'(bus.out_regwrite), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // No hazard
    beat(ALU_ADD, 5'd1, 5'd2, 32'd5, 32'd7);
    step("nohaz");
    chk("nohaz_srca_const", bus.srca, 32'd5);
    chk("nohaz_srcb_const", bus.srcb, 32'd7);

    // Forwarding priority
    beat(ALU_OR, 5'd3, 5'd1, 32'h11, 32'h22);
    exm_regwrite = 1'b1; exm_rd = 5'd3; exm_result = 32'hAA;
    wb_regwrite = 1'b1; wb_rd = 5'd3; wb_result = 32'hBB;
    step("prio_exm");
    chk("prio_exm_const", bus.srca, 32'hAA);
    exm_rd = 5'd4;
    step("prio_wb");
    chk("prio_wb_const", bus.srca, 32'hBB);
    beat(ALU_OR, 5'd0, 5'd1, 32'h77, 32'h22);
    exm_rd = 5'd0; wb_rd = 5'd0;
    step("x0");
    chk("x0_const", bus.srca, 32'h77);

    // Immediate is never forwarded
    beat(ALU_SUB, 5'd1, 5'd3, 32'h1, 32'h22);
    bus.in_alusrc = 1'b1; bus.in_imm = 32'hFFFF_FFFC;
    exm_rd = 5'd3; wb_regwrite = 1'b0;
    step("imm");
    chk("imm_const", bus.srcb, 32'hFFFF_FFFC);

    // Stall snoop
    idle();
    beat(ALU_AND, 5'd9, 5'd0, 32'h55, 32'h66);
    step("snp_cap");
    bus.out_ready = 1'b0;
    beat(ALU_SLT, 5'd2, 5'd2, 32'h99, 32'h99);
    step("snp_c1");
    chk("snp_c1_in_ready", 32'(bus.in_ready), 32'd0);
    wb_regwrite = 1'b1; wb_rd = 5'd9; wb_result = 32'h1234;
    step("snp_c2");
    chk("snp_c2_srca", bus.srca, 32'h1234);
    wb_regwrite = 1'b0; wb_result = 32'h0;
    step("snp_c3");
    chk("snp_c3_srca", bus.srca, 32'h1234);
    chk("snp_c3_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step("snp_consume");
    chk("snp_consume_valid", 32'(bus.out_valid), 32'd0);
    step("snp_once");

    // Flush while stalled
    beat(ALU_ADD, 5'd5, 5'd6, 32'hCAFE, 32'hBEEF);
    bus.out_ready = 1'b0;
    step("fl_cap");
    beat(ALU_SUB, 5'd7, 5'd8, 32'h1, 32'h2);
    flush = 1'b1;
    step("fl_kill");
    chk("fl_kill_valid", 32'(bus.out_valid), 32'd0);
    flush = 1'b0; bus.out_ready = 1'b1;
    step("fl_resume");
    chk("fl_resume_valid", 32'(bus.out_valid), 32'd1);

    // Reset asserted mid-stall
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rstmid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rstmid_srca", bus.srca, 32'd0);
    chk("rstmid_srcb", bus.srcb, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstmid_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // Randomized traffic with small index range to provoke hazards
    repeat (400) begin
      bus.in_valid      = ($urandom_range(0, 3) != 0);
      bus.in_alucontrol = 3'($urandom_range(0, 7));
      bus.in_alusrc     = 1'($urandom_range(0, 1));
      bus.in_rs1        = 5'($urandom_range(0, 3));
      bus.in_rs2        = 5'($urandom_range(0, 3));
      bus.in_rd         = 5'($urandom_range(0, 31));
      bus.in_regwrite   = 1'($urandom_range(0, 1));
      bus.in_rd1        = $urandom;
      bus.in_rd2        = $urandom;
      bus.in_imm        = $urandom;
      bus.out_ready     = ($urandom_range(0, 2) != 0);
      flush             = ($urandom_range(0, 9) == 0);
      exm_regwrite      = 1'($urandom_range(0, 1));
      exm_rd            = 5'($urandom_range(0, 3));
      exm_result        = $urandom;
      wb_regwrite       = 1'($urandom_range(0, 1));
      wb_rd             = 5'($urandom_range(0, 3));
      wb_result         = $urandom;
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
